// File: rtl/maj_pkg.sv
// Shared types and constants for the majority-gate serial adder.
package maj_pkg;

  // Sequencer states: waiting for a start request, or shifting bits through the adder.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default operand width used when the parent does not override WIDTH.
  localparam int MAJ_DEFAULT_WIDTH = 8;

  // Bit-counter width: enough to count 0 .. width-1 (width >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/maj_fa.sv
// Majority-gate full adder: MAJ3 produces the carry, MAJ5 produces the sum
// from (a, b, cin, ~cout, ~cout). Purely combinational.

module maj_3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

module maj_5 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic y
);
  logic [2:0] ones;
  assign ones = 3'(a) + 3'(b) + 3'(c) + 3'(d) + 3'(e);
  assign y    = (ones >= 3'd3);
endmodule

module maj_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic cout_n;

  maj_3 u_carry (
    .a (a),
    .b (b),
    .c (cin),
    .y (cout)
  );

  assign cout_n = ~cout;

  // Two copies of ~cout cancel the majority exactly when two or more inputs are set,
  // leaving the parity of a/b/cin.
  maj_5 u_sum (
    .a (a),
    .b (b),
    .c (cin),
    .d (cout_n),
    .e (cout_n),
    .y (sum)
  );
endmodule

// File: rtl/maj_serial_adder.sv
// Bit-serial WIDTH-bit adder around maj_fa: operands load in parallel on start,
// are added LSB-first one bit per clock, and the result is published in parallel
// with a one-cycle done pulse.
// Optional build macro: MAJ_SERIAL_OVF_EN adds a signed-overflow output ovf.

module maj_serial_adder
  import maj_pkg::*;
#(
  parameter int WIDTH = MAJ_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef MAJ_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             done_q,   done_d;
`ifdef MAJ_SERIAL_OVF_EN
  logic             ovf_q,    ovf_d;
`endif

  logic fa_sum;
  logic fa_cout;

  // The single adder cell sees the current LSBs and the carry fed back from the previous bit.
  maj_fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state logic: load on start in IDLE, shift one bit per clock in RUN, publish on the last bit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef MAJ_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_sum, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef MAJ_SERIAL_OVF_EN
          // On the last bit carry_q holds the carry entering the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MAJ_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef MAJ_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
`ifdef MAJ_SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
